// File: rtl/disparity_bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_arb_pkg
// Purpose  : Shared types and defaults for the disparity BRAM arbiter.
//            Holds the grant encoding, the default BRAM geometry, the
//            statistics counter width and the round-robin decision.
// Revision : 1.0  initial release
// ============================================================================
package disp_arb_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WR   = 2'd1,
    GRANT_RD   = 2'd2
  } grant_e;

  localparam int DISP_DATA_W       = 8;
  localparam int DISP_DEPTH        = 76800;   // 320 x 240 disparity map
  localparam int DISP_READ_LATENCY = 2;
  localparam int STAT_W            = 16;

  // Round-robin between the two requesters. last_was_wr is the pointer:
  // when both request, whoever was not served last wins. A lone requester
  // is always served.
  function automatic grant_e arbitrate(input logic wr_req,
                                       input logic rd_req,
                                       input logic last_was_wr);
    grant_e result;
    result = GRANT_NONE;
    if (wr_req && (!rd_req || !last_was_wr)) begin
      result = GRANT_WR;
    end else if (rd_req) begin
      result = GRANT_RD;
    end
    return result;
  endfunction

endpackage : disp_arb_pkg
`default_nettype wire

// File: rtl/disparity_bram_arbiter_read_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : read_tag_pipe
// Purpose  : STAGES-deep single-bit shift register carrying "a read was
//            issued" tags alongside the BRAM read latency.
// Ports    : clk    - clock
//            rst    - asynchronous active-high reset, clears every tag
//            i_tag  - tag inserted into stage 0 on each edge
//            o_tail - last stage; high when the matching read data is due
// Revision : 1.0  initial release
// ============================================================================
module read_tag_pipe #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tag,
  output logic o_tail
);

  logic [STAGES-1:0] r_tags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tags <= '0;
    end else begin
      r_tags <= {r_tags[STAGES-2:0], i_tag};
    end
  end

  assign o_tail = r_tags[STAGES-1];

endmodule : read_tag_pipe
`default_nettype wire

// File: rtl/disparity_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : disparity_bram_arbiter
// Purpose  : Shares the single-port disparity result BRAM between the stereo
//            engine (write only) and the UART readout (read only). Round-robin
//            arbitration, one access per cycle, registered BRAM drive and
//            read-return tracking across the BRAM read latency.
// Ports    : clk_in/rst_in              clock, async active-high reset
//            wr_req/addr/data_in        write request (held until granted)
//            wr_grant_out               write accepted this cycle (comb)
//            rd_req/addr_in             read request (held until granted)
//            rd_grant_out               read accepted this cycle (comb)
//            rd_valid_out/rd_data_out   returned read data
//            bram_addr/we/din_out       registered BRAM drive
//            bram_dout_in               BRAM read data
//            addr_err_out               sticky out-of-range flag
//            wr/rd/conflict_count_out   statistics counters
// Config   : define DISPARITY_ARB_STATS_EN to build the saturating
//            statistics counters; otherwise the counter ports read 0.
// Revision : 1.0  initial release
// ============================================================================
module disparity_bram_arbiter
  import disp_arb_pkg::*;
#(
  parameter int DATA_W       = DISP_DATA_W,
  parameter int DEPTH        = DISP_DEPTH,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int READ_LATENCY = DISP_READ_LATENCY
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_req_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_grant_out,
  input  logic              rd_req_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic              rd_grant_out,
  output logic              rd_valid_out,
  output logic [DATA_W-1:0] rd_data_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic              bram_we_out,
  output logic [DATA_W-1:0] bram_din_out,
  input  logic [DATA_W-1:0] bram_dout_in,
  output logic              addr_err_out,
  output logic [STAT_W-1:0] wr_count_out,
  output logic [STAT_W-1:0] rd_count_out,
  output logic [STAT_W-1:0] conflict_count_out
);

  // One extra bit so DEPTH is representable even when it is 2**ADDR_W.
  localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W+1)'(DEPTH);

  grant_e            w_grant;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_tag_in;
  logic              w_tag_tail;

  logic              r_last_wr;      // 1: write was the most recent grant
  logic [ADDR_W-1:0] r_bram_addr;
  logic              r_bram_we;
  logic [DATA_W-1:0] r_bram_din;
  logic              r_addr_err;
  logic [DATA_W-1:0] r_rd_hold;      // last returned read word

  // --------------------------------------------------------------------------
  // Arbitration (combinational, same cycle as the request)
  // --------------------------------------------------------------------------
  assign w_wr_in_range = ({1'b0, wr_addr_in} < c_depth_ext);
  assign w_rd_in_range = ({1'b0, rd_addr_in} < c_depth_ext);

  always_comb begin
    w_grant = arbitrate(wr_req_in, rd_req_in, r_last_wr);
  end

  assign wr_grant_out = (w_grant == GRANT_WR);
  assign rd_grant_out = (w_grant == GRANT_RD);

  // --------------------------------------------------------------------------
  // Issue register. Out-of-range accesses are still granted so the requester
  // never stalls, but they leave the BRAM drive untouched (we stays 0) and
  // only raise the sticky error.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_last_wr   <= 1'b0;             // read "last" so write is favoured
      r_bram_addr <= '0;
      r_bram_we   <= 1'b0;
      r_bram_din  <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_bram_we <= 1'b0;
      case (w_grant)
        GRANT_WR: begin
          r_last_wr <= 1'b1;
          if (w_wr_in_range) begin
            r_bram_addr <= wr_addr_in;
            r_bram_we   <= 1'b1;
            r_bram_din  <= wr_data_in;
          end else begin
            r_addr_err <= 1'b1;
          end
        end
        GRANT_RD: begin
          r_last_wr <= 1'b0;
          if (w_rd_in_range) begin
            r_bram_addr <= rd_addr_in;
            r_bram_din  <= '0;
          end else begin
            r_addr_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bram_addr_out = r_bram_addr;
  assign bram_we_out   = r_bram_we;
  assign bram_din_out  = r_bram_din;
  assign addr_err_out  = r_addr_err;

  // --------------------------------------------------------------------------
  // Read return. The tag enters the pipe on the same edge that drives the
  // BRAM address, so after READ_LATENCY+1 stages its tail lines up with the
  // cycle the BRAM output is valid. Data is passed straight through on that
  // cycle and held afterwards.
  // --------------------------------------------------------------------------
  assign w_tag_in = (w_grant == GRANT_RD) && w_rd_in_range;

  read_tag_pipe #(
    .STAGES (READ_LATENCY + 1)
  ) u_read_tag_pipe (
    .clk    (clk_in),
    .rst    (rst_in),
    .i_tag  (w_tag_in),
    .o_tail (w_tag_tail)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_hold <= '0;
    end else if (w_tag_tail) begin
      r_rd_hold <= bram_dout_in;
    end
  end

  assign rd_valid_out = w_tag_tail;
  assign rd_data_out  = w_tag_tail ? bram_dout_in : r_rd_hold;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef DISPARITY_ARB_STATS_EN
  localparam logic [STAT_W-1:0] c_stat_max = '1;

  logic [STAT_W-1:0] r_wr_count;
  logic [STAT_W-1:0] r_rd_count;
  logic [STAT_W-1:0] r_conflict_count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_count       <= '0;
      r_rd_count       <= '0;
      r_conflict_count <= '0;
    end else begin
      if ((w_grant == GRANT_WR) && w_wr_in_range && (r_wr_count != c_stat_max)) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
      if ((w_grant == GRANT_RD) && w_rd_in_range && (r_rd_count != c_stat_max)) begin
        r_rd_count <= r_rd_count + 1'b1;
      end
      if (wr_req_in && rd_req_in && (r_conflict_count != c_stat_max)) begin
        r_conflict_count <= r_conflict_count + 1'b1;
      end
    end
  end

  assign wr_count_out       = r_wr_count;
  assign rd_count_out       = r_rd_count;
  assign conflict_count_out = r_conflict_count;
`else
  assign wr_count_out       = '0;
  assign rd_count_out       = '0;
  assign conflict_count_out = '0;
`endif

endmodule : disparity_bram_arbiter
`default_nettype wire

// File: tb/tb_disparity_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_disparity_bram_arbiter
// Purpose  : Self-checking bench for disparity_bram_arbiter with a BRAM
//            model and a transaction-level reference of the arbitration,
//            ordering and read-return rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_disparity_bram_arbiter;
  import disp_arb_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 76800;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RL     = 2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              wr_req_in = 1'b0;
  logic [ADDR_W-1:0] wr_addr_in = '0;
  logic [DATA_W-1:0] wr_data_in = '0;
  logic              wr_grant_out;
  logic              rd_req_in = 1'b0;
  logic [ADDR_W-1:0] rd_addr_in = '0;
  logic              rd_grant_out;
  logic              rd_valid_out;
  logic [DATA_W-1:0] rd_data_out;
  logic [ADDR_W-1:0] bram_addr_out;
  logic              bram_we_out;
  logic [DATA_W-1:0] bram_din_out;
  logic [DATA_W-1:0] bram_dout_in;
  logic              addr_err_out;
  logic [15:0]       wr_count_out, rd_count_out, conflict_count_out;

  always #5 clk_in = ~clk_in;

  disparity_bram_arbiter #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .wr_grant_out(wr_grant_out),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_grant_out(rd_grant_out),
    .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
    .bram_addr_out(bram_addr_out), .bram_we_out(bram_we_out),
    .bram_din_out(bram_din_out), .bram_dout_in(bram_dout_in),
    .addr_err_out(addr_err_out),
    .wr_count_out(wr_count_out), .rd_count_out(rd_count_out),
    .conflict_count_out(conflict_count_out)
  );

  // Single-port BRAM, two-cycle read latency (address reg + output reg).
  logic [DATA_W-1:0] bram_mem [DEPTH];
  logic [DATA_W-1:0] bram_p1 = '0;
  initial bram_dout_in = '0;
  initial for (int i = 0; i < DEPTH; i++) bram_mem[i] = '0;
  always @(posedge clk_in) begin
    if (bram_we_out) bram_mem[bram_addr_out] <= bram_din_out;
    bram_p1      <= bram_mem[bram_addr_out];
    bram_dout_in <= bram_p1;
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]        ref_mem [int];     // contents in grant order
  bit                m_last_wr;
  bit                m_err;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_din;
  bit                m_chk_addr, m_chk_din;
  int                m_due [$];
  logic [7:0]        m_rdata [$];
  logic [7:0]        m_last_rdata;
  int                m_wr_cnt, m_rd_cnt, m_cf_cnt;

  function automatic logic [7:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic void model_clear();
    m_last_wr = 0; m_err = 0; m_we = 0; m_addr = '0; m_din = '0;
    m_chk_addr = 1; m_chk_din = 1; m_last_rdata = '0;
    m_due.delete(); m_rdata.delete();
    m_wr_cnt = 0; m_rd_cnt = 0; m_cf_cnt = 0;
  endfunction

  // Called just after a falling edge with the inputs for this cycle applied.
  // g returns the expected grant: 0 none, 1 write, 2 read.
  task automatic step(output int g);
    bit       exp_v;
    logic [7:0] exp_d;
    #1;
    check("bram_we", bram_we_out, m_we);
    if (m_chk_addr) check("bram_addr", bram_addr_out, m_addr);
    if (m_chk_din)  check("bram_din", bram_din_out, m_din);
    check("addr_err", addr_err_out, m_err);
`ifdef DISPARITY_ARB_STATS_EN
    check("wr_count", wr_count_out, m_wr_cnt);
    check("rd_count", rd_count_out, m_rd_cnt);
    check("conflict_count", conflict_count_out, m_cf_cnt);
`else
    check("wr_count", wr_count_out, 0);
    check("rd_count", rd_count_out, 0);
    check("conflict_count", conflict_count_out, 0);
`endif
    exp_v = (m_due.size() > 0) && (m_due[0] == cyc);
    exp_d = m_last_rdata;
    if (exp_v) begin
      exp_d = m_rdata[0];
      m_last_rdata = exp_d;
      void'(m_due.pop_front());
      void'(m_rdata.pop_front());
    end
    check("rd_valid", rd_valid_out, exp_v);
    check("rd_data", rd_data_out, exp_d);

    // Grant rule: lone requester wins; on contention the one not served last.
    if (wr_req_in && rd_req_in) g = m_last_wr ? 2 : 1;
    else if (wr_req_in)         g = 1;
    else if (rd_req_in)         g = 2;
    else                        g = 0;
    check("wr_grant", wr_grant_out, (g == 1));
    check("rd_grant", rd_grant_out, (g == 2));

    if (wr_req_in && rd_req_in) m_cf_cnt++;
    m_we = 0;
    if (g == 1) begin
      m_last_wr = 1;
      if (int'(wr_addr_in) < DEPTH) begin
        m_we = 1; m_addr = wr_addr_in; m_din = wr_data_in;
        m_chk_addr = 1; m_chk_din = 1;
        ref_mem[int'(wr_addr_in)] = wr_data_in;
        m_wr_cnt++;
      end else begin
        m_err = 1; m_chk_addr = 0; m_chk_din = 0;
      end
    end else if (g == 2) begin
      m_last_wr = 0;
      if (int'(rd_addr_in) < DEPTH) begin
        m_addr = rd_addr_in; m_din = '0;
        m_chk_addr = 1; m_chk_din = 1;
        m_due.push_back(cyc + 1 + RL);
        m_rdata.push_back(ref_read(int'(rd_addr_in)));
        m_rd_cnt++;
      end else begin
        m_err = 1; m_chk_addr = 0; m_chk_din = 0;
      end
    end else begin
      m_chk_din = 0;
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Called at a falling edge; pulses reset for one cycle mid-operation.
  task automatic do_reset();
    wr_req_in = 0; rd_req_in = 0;
    rst_in = 1;
    #1;
    check("rst_bram_we", bram_we_out, 0);
    check("rst_bram_addr", bram_addr_out, 0);
    check("rst_bram_din", bram_din_out, 0);
    check("rst_rd_valid", rd_valid_out, 0);
    check("rst_rd_data", rd_data_out, 0);
    check("rst_addr_err", addr_err_out, 0);
    check("rst_counts", {wr_count_out, rd_count_out} | 32'(conflict_count_out), 0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 0;
    model_clear();
  endtask

  initial begin
    int g;
    model_clear();
    @(negedge clk_in);
    do_reset();

    // Write only: three back-to-back writes.
    for (int i = 0; i < 3; i++) begin
      wr_req_in = 1; wr_addr_in = ADDR_W'(10 + i); wr_data_in = 8'(5 + i);
      step(g);
      check("wo_grant", g, 1);
    end
    wr_req_in = 0;
    step(g);

    // Read only: address 11 returns 6 three cycles later.
    rd_req_in = 1; rd_addr_in = ADDR_W'(11);
    step(g);
    rd_req_in = 0;
    repeat (4) step(g);
    check("ro_data", rd_data_out, 8'd6);

    // Contention from reset: W,R,W,R,W,R.
    do_reset();
    wr_req_in = 1; wr_addr_in = ADDR_W'(200); wr_data_in = 8'hA0;
    rd_req_in = 1; rd_addr_in = ADDR_W'(10);
    for (int i = 0; i < 6; i++) begin
      step(g);
      check("cont_order", g, (i % 2 == 0) ? 1 : 2);
      if (g == 1) begin wr_addr_in = wr_addr_in + 1'b1; wr_data_in = wr_data_in + 1'b1; end
      if (g == 2) rd_addr_in = rd_addr_in + 1'b1;
    end
    wr_req_in = 0; rd_req_in = 0;
    repeat (4) step(g);

    // Out of range write: granted, dropped, sticky error.
    wr_req_in = 1; wr_addr_in = ADDR_W'(DEPTH); wr_data_in = 8'h99;
    step(g);
    wr_req_in = 0;
    repeat (3) step(g);
    check("oor_err_sticky", addr_err_out, 1);

    // Reset while a read is in flight: no rd_valid afterwards.
    do_reset();
    rd_req_in = 1; rd_addr_in = ADDR_W'(11);
    step(g);
    rd_req_in = 0;
    do_reset();
    repeat (5) step(g);

    // Read after write to the same address.
    wr_req_in = 1; wr_addr_in = ADDR_W'(100); wr_data_in = 8'd42;
    step(g);
    wr_req_in = 0; rd_req_in = 1; rd_addr_in = ADDR_W'(100);
    step(g);
    rd_req_in = 0;
    repeat (4) step(g);
    check("raw_data", rd_data_out, 8'd42);

    // Randomised traffic, requests held until granted.
    for (int i = 0; i < 400; i++) begin
      if (!wr_req_in && $urandom_range(0, 99) < 60) begin
        wr_req_in = 1; wr_addr_in = ADDR_W'($urandom_range(0, 31)); wr_data_in = 8'($urandom);
      end
      if (!rd_req_in && $urandom_range(0, 99) < 60) begin
        rd_req_in = 1; rd_addr_in = ADDR_W'($urandom_range(0, 31));
      end
      step(g);
      if (g == 1) wr_req_in = 0;
      if (g == 2) rd_req_in = 0;
    end
    wr_req_in = 0; rd_req_in = 0;
    repeat (5) step(g);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_disparity_bram_arbiter
`default_nettype wire
